pc_sequencer: RTL and testbench

Next-PC controller for the 8-bit RISC core. Owns the program-counter register and sequences its update each fetch: sequential increment, PC-relative branch through the branch-target adder path (PC + offset), absolute jump, and call/return through a small return-address stack. Handshakes with instruction memory and honours pipeline stalls and halt; sits between the decode/branch-resolve logic and the instruction-memory address port.

---
 rtl/pc_sequencer.sv | 130 +++++++++++++
 tb/tb_pc_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the program counter and sequences increment, branch,
// jump and call/return (via a small return-address stack) against fetch handshakes.
module pc_sequencer #(
  parameter logic [7:0]  RESET_VECTOR = 8'h00,
  parameter int unsigned STACK_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ready,
  input  logic       stall,
  input  logic       br_take,
  input  logic [7:0] br_offset,
  input  logic       jmp,
  input  logic       call,
  input  logic       ret,
  input  logic [7:0] jmp_addr,
  input  logic       halt,
  input  logic       resume,
  output logic [7:0] pc,
  output logic       stack_empty,
  output logic       stack_full,
  output logic       err
);

  localparam int unsigned AddrW = 8;
  localparam int unsigned PtrW  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW  = $clog2(STACK_DEPTH);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } seqState_e;

  seqState_e        state, stateNext;
  logic [AddrW-1:0] pcQ, pcNext;
  logic [PtrW-1:0]  ptrQ, ptrNext;
  logic             errQ, errNext;
  logic             reqQ, emptyQ, fullQ;
  logic             push;
  logic             advance;
  logic [AddrW-1:0] retAddr;
  logic [AddrW-1:0] stackTop;
  logic [AddrW-1:0] stackMem [STACK_DEPTH];

  assign advance  = imem_ready & ~stall & ~halt;
  assign retAddr  = pcQ + AddrW'(1);
  assign stackTop = stackMem[IdxW'(ptrQ - PtrW'(1))];

  // Next state, next PC and stack pointer; control inputs only matter on advance.
  always_comb begin
    stateNext = state;
    pcNext    = pcQ;
    ptrNext   = ptrQ;
    errNext   = errQ;
    push      = 1'b0;
    case (state)
      BOOT: stateNext = FETCH;
      FETCH: begin
        if (halt) begin
          stateNext = HALT;
        end else if (advance) begin
          if (ret) begin
            if (ptrQ != PtrW'(0)) begin
              pcNext  = stackTop;
              ptrNext = ptrQ - PtrW'(1);
            end else begin
              errNext   = 1'b1;
              stateNext = HALT;
            end
          end else if (call) begin
            if (ptrQ != PtrW'(STACK_DEPTH)) begin
              push    = 1'b1;
              pcNext  = jmp_addr;
              ptrNext = ptrQ + PtrW'(1);
            end else begin
              errNext   = 1'b1;
              stateNext = HALT;
            end
          end else if (jmp) begin
            pcNext = jmp_addr;
          end else if (br_take) begin
            pcNext = pcQ + br_offset;
          end else begin
            pcNext = retAddr;
          end
        end
      end
      HALT: begin
        if (resume && !errQ) stateNext = FETCH;
      end
      default: stateNext = BOOT;
    endcase
  end

  // Flags are registered from next-state values so they move with the PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BOOT;
      pcQ    <= RESET_VECTOR;
      ptrQ   <= '0;
      errQ   <= 1'b0;
      reqQ   <= 1'b0;
      emptyQ <= 1'b1;
      fullQ  <= 1'b0;
    end else begin
      state  <= stateNext;
      pcQ    <= pcNext;
      ptrQ   <= ptrNext;
      errQ   <= errNext;
      reqQ   <= (stateNext == FETCH);
      emptyQ <= (ptrNext == PtrW'(0));
      fullQ  <= (ptrNext == PtrW'(STACK_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) stackMem[IdxW'(ptrQ)] <= retAddr;
  end

  assign imem_req    = reqQ;
  assign imem_addr   = pcQ;
  assign pc          = pcQ;
  assign stack_empty = emptyQ;
  assign stack_full  = fullQ;
  assign err         = errQ;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;

  localparam logic [7:0]  ResetVec = 8'h10;
  localparam int unsigned Depth    = 4;
  localparam int          ModeBoot  = 0;
  localparam int          ModeFetch = 1;
  localparam int          ModeHalt  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ready;
  logic       stall;
  logic       br_take;
  logic [7:0] br_offset;
  logic       jmp;
  logic       call;
  logic       ret;
  logic [7:0] jmp_addr;
  logic       halt;
  logic       resume;
  logic [7:0] pc;
  logic       stack_empty;
  logic       stack_full;
  logic       err;

  int checkCount = 0;
  int errorCount = 0;

  // reference model state
  int         mMode;
  logic [7:0] mPc;
  logic       mErr;
  logic [7:0] mStack [$];

  pc_sequencer #(.RESET_VECTOR(ResetVec), .STACK_DEPTH(Depth)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .stall(stall), .br_take(br_take), .br_offset(br_offset),
    .jmp(jmp), .call(call), .ret(ret), .jmp_addr(jmp_addr), .halt(halt),
    .resume(resume), .pc(pc), .stack_empty(stack_empty), .stack_full(stack_full),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mMode = ModeBoot;
    mPc   = ResetVec;
    mErr  = 1'b0;
    mStack.delete();
  endtask

  task automatic modelStep();
    if (!rst_n) begin
      modelReset();
    end else if (mMode == ModeBoot) begin
      mMode = ModeFetch;
    end else if (mMode == ModeHalt) begin
      if (resume && !mErr) mMode = ModeFetch;
    end else if (halt) begin
      mMode = ModeHalt;
    end else if (imem_ready && !stall) begin
      if (ret) begin
        if (mStack.size() > 0) mPc = mStack.pop_back();
        else begin mErr = 1'b1; mMode = ModeHalt; end
      end else if (call) begin
        if (mStack.size() < Depth) begin
          mStack.push_back(8'(mPc + 8'd1));
          mPc = jmp_addr;
        end else begin mErr = 1'b1; mMode = ModeHalt; end
      end else if (jmp) mPc = jmp_addr;
      else if (br_take) mPc = 8'(mPc + br_offset);
      else mPc = 8'(mPc + 8'd1);
    end
  endtask

  task automatic checkAll(input string tag);
    checkVal({tag, ".pc"}, 32'(pc), 32'(mPc));
    checkVal({tag, ".addr"}, 32'(imem_addr), 32'(mPc));
    checkVal({tag, ".req"}, 32'(imem_req), 32'(mMode == ModeFetch));
    checkVal({tag, ".empty"}, 32'(stack_empty), 32'(mStack.size() == 0));
    checkVal({tag, ".full"}, 32'(stack_full), 32'(mStack.size() == Depth));
    checkVal({tag, ".err"}, 32'(err), 32'(mErr));
  endtask

  task automatic clearCtl();
    stall = 1'b0; br_take = 1'b0; br_offset = 8'h00; jmp = 1'b0; call = 1'b0;
    ret = 1'b0; jmp_addr = 8'h00; halt = 1'b0; resume = 1'b0;
  endtask

  task automatic stepCycle(input string tag);
    @(posedge clk);
    modelStep();
    #1;
    checkAll(tag);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic jumpTo(input logic [7:0] addr);
    jmp = 1'b1; jmp_addr = addr;
    stepCycle("jump");
    clearCtl();
  endtask

  initial begin
    rst_n = 1'b1;
    imem_ready = 1'b1;
    clearCtl();
    modelReset();
    #2;
    doReset();

    // boot then sequential fetch from the reset vector
    stepCycle("boot");
    checkVal("boot_req", 32'(imem_req), 32'd1);
    checkVal("boot_pc", 32'(pc), 32'h10);
    stepCycle("seq1");
    checkVal("seq_pc11", 32'(pc), 32'h11);
    stepCycle("seq2");
    checkVal("seq_pc12", 32'(pc), 32'h12);

    jumpTo(8'hFE);
    stepCycle("wrap1");
    stepCycle("wrap2");
    checkVal("wrap_pc00", 32'(pc), 32'h00);

    // stalled branch holds, unstalled branch goes backwards
    jumpTo(8'h20);
    br_take = 1'b1; br_offset = 8'hFC; stall = 1'b1;
    stepCycle("br_stall");
    checkVal("br_stall_pc", 32'(pc), 32'h20);
    checkVal("br_stall_req", 32'(imem_req), 32'd1);
    stall = 1'b0;
    stepCycle("br_take");
    checkVal("br_pc1c", 32'(pc), 32'h1C);
    clearCtl();

    // call beats jmp and branch; return lands after the call site
    jumpTo(8'h05);
    call = 1'b1; jmp = 1'b1; br_take = 1'b1; br_offset = 8'h33; jmp_addr = 8'h40;
    stepCycle("call");
    checkVal("call_pc40", 32'(pc), 32'h40);
    checkVal("call_nonempty", 32'(stack_empty), 32'd0);
    clearCtl();
    stepCycle("in_sub");
    ret = 1'b1;
    stepCycle("ret");
    checkVal("ret_pc06", 32'(pc), 32'h06);
    checkVal("ret_empty", 32'(stack_empty), 32'd1);
    clearCtl();

    // overflow the return stack
    for (int i = 0; i < 4; i++) begin
      call = 1'b1; jmp_addr = 8'(8'h50 + 8'(i));
      stepCycle("nest");
    end
    checkVal("nest_full", 32'(stack_full), 32'd1);
    jmp_addr = 8'h99;
    stepCycle("overflow");
    checkVal("ovf_err", 32'(err), 32'd1);
    checkVal("ovf_req", 32'(imem_req), 32'd0);
    checkVal("ovf_pc", 32'(pc), 32'h53);
    clearCtl();
    resume = 1'b1;
    for (int i = 0; i < 3; i++) stepCycle("ovf_resume");
    checkVal("ovf_stuck", 32'(imem_req), 32'd0);
    clearCtl();
    doReset();

    // underflow
    stepCycle("boot2");
    ret = 1'b1;
    stepCycle("underflow");
    checkVal("udf_err", 32'(err), 32'd1);
    checkVal("udf_pc", 32'(pc), 32'h10);
    clearCtl();
    doReset();

    // halt / resume, then async reset while memory is not ready
    stepCycle("boot3");
    stepCycle("pre_halt");
    halt = 1'b1; jmp = 1'b1; jmp_addr = 8'hAA;
    stepCycle("halt");
    checkVal("halt_req", 32'(imem_req), 32'd0);
    checkVal("halt_pc", 32'(pc), 32'h11);
    clearCtl();
    stepCycle("halted");
    resume = 1'b1;
    stepCycle("resume");
    checkVal("resume_req", 32'(imem_req), 32'd1);
    resume = 1'b0;
    stepCycle("post_resume");
    checkVal("post_resume_pc", 32'(pc), 32'h12);
    imem_ready = 1'b0;
    stepCycle("wait1");
    stepCycle("wait2");
    rst_n = 1'b0;
    #1;
    checkVal("async_pc", 32'(pc), 32'h10);
    checkVal("async_req", 32'(imem_req), 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    imem_ready = 1'b1;

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      imem_ready = ($urandom_range(0, 3) != 0);
      stall      = ($urandom_range(0, 4) == 0);
      halt       = ($urandom_range(0, 19) == 0);
      resume     = ($urandom_range(0, 2) == 0);
      ret        = ($urandom_range(0, 6) == 0);
      call       = ($urandom_range(0, 5) == 0);
      jmp        = ($urandom_range(0, 9) == 0);
      br_take    = ($urandom_range(0, 2) == 0);
      br_offset  = 8'($urandom);
      jmp_addr   = 8'($urandom);
      stepCycle("rand");
      if ((mErr && $urandom_range(0, 9) == 0) || $urandom_range(0, 79) == 0) doReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
